// File: rtl/touch_pkg.sv
// Shared types and default tuning for the touch-panel position filter.
package touch_pkg;

    localparam int COORD_W = 12;
    localparam int FLAG_W  = 8;

    localparam int AVG_LOG2_DEF   = 2;
    localparam int JUMP_MAX_DEF   = 200;
    localparam int TOUCH_CNT_DEF  = 2;
    localparam int LOST_CNT_DEF   = 3;
    localparam int REJECT_MAX_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2
    } state_e;

    // Magnitude of a - b evaluated as a 13-bit signed difference.
    function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        logic [COORD_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        abs_diff = d[COORD_W] ? (~d + (COORD_W+1)'(1)) : d;
    endfunction

endpackage

// File: rtl/touch_avg_axis.sv
// One axis of the moving average: circular sample buffer, running sum and mean.
// The write pointer comes from the parent so X and Y always share a slot.
module touch_avg_axis
    import touch_pkg::*;
#(
    parameter int AVG_LOG2 = AVG_LOG2_DEF
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                accept,
    input  logic                preload,
    input  logic [COORD_W-1:0]  sample,
    input  logic [AVG_LOG2-1:0] wp,
    output logic [COORD_W-1:0]  mean
);
    localparam int N     = 1 << AVG_LOG2;
    localparam int SUM_W = COORD_W + AVG_LOG2;

    logic [COORD_W-1:0] buf_q [N];
    logic [COORD_W-1:0] buf_d [N];
    logic [SUM_W-1:0]   sum_q;
    logic [SUM_W-1:0]   sum_d;

    // Buffer and running-sum update for preload or single-slot replacement.
    always_comb begin
        buf_d = buf_q;
        sum_d = sum_q;
        if (preload) begin
            for (int i = 0; i < N; i++) begin
                buf_d[i] = sample;
            end
            sum_d = {sample, {AVG_LOG2{1'b0}}};
        end else if (accept) begin
            buf_d[wp] = sample;
            sum_d     = sum_q - SUM_W'(buf_q[wp]) + SUM_W'(sample);
        end else begin
            buf_d = buf_q;
            sum_d = sum_q;
        end
    end

    // Buffer and sum registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= {COORD_W{1'b0}};
            end
            sum_q <= {SUM_W{1'b0}};
        end else begin
            buf_q <= buf_d;
            sum_q <= sum_d;
        end
    end

    assign mean = sum_q[SUM_W-1:AVG_LOG2];

endmodule

// File: rtl/touch_pos_filter.sv
// Touch frame detect, touch debounce, jump rejection and moving-average position.
// Optional frame watchdog (stale output) is built only with TOUCH_TIMEOUT_EN defined.
module touch_pos_filter
    import touch_pkg::*;
#(
    parameter int AVG_LOG2   = AVG_LOG2_DEF,
    parameter int TOUCH_CNT  = TOUCH_CNT_DEF,
    parameter int LOST_CNT   = LOST_CNT_DEF,
    parameter int JUMP_MAX   = JUMP_MAX_DEF,
    parameter int REJECT_MAX = REJECT_MAX_DEF
`ifdef TOUCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 5000000
`endif
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic [FLAG_W-1:0]  touched_in,
    input  logic               frame_valid_in,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               pos_valid,
    output logic               ball_present,
    output logic [7:0]         reject_cnt,
    output logic               stale
);
    localparam int TC_W = $clog2(TOUCH_CNT + 2);
    localparam int LC_W = $clog2(LOST_CNT + 2);
    localparam int RC_W = $clog2(REJECT_MAX + 2);

    logic               valid_q, valid_d;
    logic               smp_go_q, smp_go_d;
    logic               upd_go_q, upd_go_d;
    logic [COORD_W-1:0] x_smp_q, x_smp_d;
    logic [COORD_W-1:0] y_smp_q, y_smp_d;
    logic               touch_smp_q, touch_smp_d;
    state_e             state_q, state_d;
    logic [TC_W-1:0]    tcnt_q, tcnt_d;
    logic [LC_W-1:0]    lcnt_q, lcnt_d;
    logic [RC_W-1:0]    rcnt_q, rcnt_d;
    logic [AVG_LOG2-1:0] wp_q, wp_d;
    logic [7:0]         reject_cnt_q, reject_cnt_d;
    logic               pos_valid_q, pos_valid_d;
    logic               present_q, present_d;

    logic               frame_edge_s;
    logic               in_range_s;
    logic               accept_s;
    logic               preload_s;
    logic               reject_s;
    logic               tmo_hit_s;
    logic [COORD_W-1:0] mean_x_s;
    logic [COORD_W-1:0] mean_y_s;

    // Edge detect and the two-stage frame pipeline; coordinates settle one cycle after the edge.
    always_comb begin
        valid_d      = frame_valid_in;
        frame_edge_s = frame_valid_in & ~valid_q;
        smp_go_d     = frame_edge_s & ~smp_go_q & ~upd_go_q;
        upd_go_d     = smp_go_q;
        if (smp_go_q) begin
            x_smp_d     = x_in;
            y_smp_d     = y_in;
            touch_smp_d = |touched_in;
        end else begin
            x_smp_d     = x_smp_q;
            y_smp_d     = y_smp_q;
            touch_smp_d = touch_smp_q;
        end
    end

    // Jump check against the current mean on both axes.
    always_comb begin
        in_range_s = (abs_diff(x_smp_q, mean_x_s) <= (COORD_W+1)'(JUMP_MAX)) &&
                     (abs_diff(y_smp_q, mean_y_s) <= (COORD_W+1)'(JUMP_MAX));
    end

    // FSM next state and frame counters.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        lcnt_d  = lcnt_q;
        rcnt_d  = rcnt_q;
        if (tmo_hit_s) begin
            state_d = ST_IDLE;
            tcnt_d  = TC_W'(0);
            lcnt_d  = LC_W'(0);
            rcnt_d  = RC_W'(0);
        end else if (upd_go_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (touch_smp_q) begin
                        tcnt_d  = TC_W'(1);
                        state_d = (TOUCH_CNT == 1) ? ST_TRACK : ST_ACQUIRE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ACQUIRE: begin
                    if (touch_smp_q) begin
                        tcnt_d  = tcnt_q + TC_W'(1);
                        state_d = (tcnt_q + TC_W'(1) == TC_W'(TOUCH_CNT)) ? ST_TRACK : ST_ACQUIRE;
                    end else begin
                        tcnt_d  = TC_W'(0);
                        state_d = ST_IDLE;
                    end
                end
                ST_TRACK: begin
                    if (touch_smp_q) begin
                        lcnt_d = LC_W'(0);
                        rcnt_d = (!in_range_s && rcnt_q < RC_W'(REJECT_MAX)) ?
                                 rcnt_q + RC_W'(1) : RC_W'(0);
                    end else if (lcnt_q == LC_W'(LOST_CNT - 1)) begin
                        state_d = ST_IDLE;
                        lcnt_d  = LC_W'(0);
                        rcnt_d  = RC_W'(0);
                    end else begin
                        lcnt_d = lcnt_q + LC_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tcnt_d  = TC_W'(0);
                    lcnt_d  = LC_W'(0);
                    rcnt_d  = RC_W'(0);
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM outputs: buffer commands, strobe, reject counter and write pointer.
    always_comb begin
        accept_s  = 1'b0;
        preload_s = 1'b0;
        reject_s  = 1'b0;
        if (upd_go_q && !tmo_hit_s && touch_smp_q) begin
            case (state_q)
                ST_IDLE:    preload_s = 1'b1;
                ST_ACQUIRE: accept_s  = 1'b1;
                ST_TRACK: begin
                    accept_s  = in_range_s;
                    reject_s  = !in_range_s && (rcnt_q < RC_W'(REJECT_MAX));
                    preload_s = !in_range_s && !(rcnt_q < RC_W'(REJECT_MAX));
                end
                default:    accept_s  = 1'b0;
            endcase
        end else begin
            accept_s = 1'b0;
        end
        pos_valid_d  = accept_s | preload_s;
        present_d    = (state_d == ST_TRACK);
        reject_cnt_d = (reject_s && reject_cnt_q != 8'hFF) ? reject_cnt_q + 8'd1 : reject_cnt_q;
        if (preload_s) begin
            wp_d = AVG_LOG2'(0);
        end else if (accept_s) begin
            wp_d = wp_q + AVG_LOG2'(1);
        end else begin
            wp_d = wp_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b1;
            smp_go_q     <= 1'b0;
            upd_go_q     <= 1'b0;
            x_smp_q      <= {COORD_W{1'b0}};
            y_smp_q      <= {COORD_W{1'b0}};
            touch_smp_q  <= 1'b0;
            state_q      <= ST_IDLE;
            tcnt_q       <= TC_W'(0);
            lcnt_q       <= LC_W'(0);
            rcnt_q       <= RC_W'(0);
            wp_q         <= AVG_LOG2'(0);
            reject_cnt_q <= 8'd0;
            pos_valid_q  <= 1'b0;
            present_q    <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            smp_go_q     <= smp_go_d;
            upd_go_q     <= upd_go_d;
            x_smp_q      <= x_smp_d;
            y_smp_q      <= y_smp_d;
            touch_smp_q  <= touch_smp_d;
            state_q      <= state_d;
            tcnt_q       <= tcnt_d;
            lcnt_q       <= lcnt_d;
            rcnt_q       <= rcnt_d;
            wp_q         <= wp_d;
            reject_cnt_q <= reject_cnt_d;
            pos_valid_q  <= pos_valid_d;
            present_q    <= present_d;
        end
    end

`ifdef TOUCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             stale_q, stale_d;

    // Watchdog: cycles since the last frame edge, saturating once expired.
    always_comb begin
        tmo_hit_s = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) & ~frame_edge_s;
        if (frame_edge_s) begin
            tmo_cnt_d = TMO_W'(0);
            stale_d   = 1'b0;
        end else begin
            tmo_cnt_d = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES)) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
            stale_d   = stale_q | tmo_hit_s;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= TMO_W'(0);
            stale_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            stale_q   <= stale_d;
        end
    end

    assign stale = stale_q;
`else
    assign tmo_hit_s = 1'b0;
    assign stale     = 1'b0;
`endif

    touch_avg_axis #(.AVG_LOG2(AVG_LOG2)) u_avg_x (
        .clk     (clk),
        .rst     (rst),
        .accept  (accept_s),
        .preload (preload_s),
        .sample  (x_smp_q),
        .wp      (wp_q),
        .mean    (mean_x_s)
    );

    touch_avg_axis #(.AVG_LOG2(AVG_LOG2)) u_avg_y (
        .clk     (clk),
        .rst     (rst),
        .accept  (accept_s),
        .preload (preload_s),
        .sample  (y_smp_q),
        .wp      (wp_q),
        .mean    (mean_y_s)
    );

    assign pos_x        = mean_x_s;
    assign pos_y        = mean_y_s;
    assign pos_valid    = pos_valid_q;
    assign ball_present = present_q;
    assign reject_cnt   = reject_cnt_q;

endmodule

// File: tb/tb_touch_pos_filter.sv
// Scoreboard bench for touch_pos_filter: directed scenarios plus random frames against a frame-level model.
module tb_touch_pos_filter;
    localparam int AVG_LOG2   = 2;
    localparam int NN         = 4;
    localparam int TOUCH_CNT  = 2;
    localparam int LOST_CNT   = 3;
    localparam int JUMP_MAX   = 200;
    localparam int REJECT_MAX = 3;
`ifdef TOUCH_TIMEOUT_EN
    localparam int TMO        = 1000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] x_in = 12'd0;
    logic [11:0] y_in = 12'd0;
    logic [7:0]  touched_in = 8'd0;
    logic        frame_valid_in = 1'b1;
    logic [11:0] pos_x;
    logic [11:0] pos_y;
    logic        pos_valid;
    logic        ball_present;
    logic [7:0]  reject_cnt;
    logic        stale;

    touch_pos_filter #(
        .AVG_LOG2   (AVG_LOG2),
        .TOUCH_CNT  (TOUCH_CNT),
        .LOST_CNT   (LOST_CNT),
        .JUMP_MAX   (JUMP_MAX),
        .REJECT_MAX (REJECT_MAX)
`ifdef TOUCH_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TMO)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .x_in           (x_in),
        .y_in           (y_in),
        .touched_in     (touched_in),
        .frame_valid_in (frame_valid_in),
        .pos_x          (pos_x),
        .pos_y          (pos_y),
        .pos_valid      (pos_valid),
        .ball_present   (ball_present),
        .reject_cnt     (reject_cnt),
        .stale          (stale)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int cyc;
        bit pv;
        int px;
        int py;
        bit bp;
        int rc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    // Frame-level reference: sample buffers, mode (0 idle, 1 acquiring, 2 tracking), run counts.
    int mbx[NN];
    int mby[NN];
    int m_wp, m_mode, m_tc, m_lc, m_rc, m_rej;

    task automatic chk(input string nm, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int m_mean(input bit y_axis);
        int s = 0;
        for (int i = 0; i < NN; i++) s += y_axis ? mby[i] : mbx[i];
        return s / NN;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NN; i++) begin
            mbx[i] = 0;
            mby[i] = 0;
        end
        m_wp = 0; m_mode = 0; m_tc = 0; m_lc = 0; m_rc = 0; m_rej = 0;
    endtask

    task automatic m_fill(input int x, input int y);
        for (int i = 0; i < NN; i++) begin
            mbx[i] = x;
            mby[i] = y;
        end
        m_wp = 0;
    endtask

    task automatic m_put(input int x, input int y);
        mbx[m_wp] = x;
        mby[m_wp] = y;
        m_wp = (m_wp + 1) % NN;
    endtask

    task automatic model_frame(input int x, input int y, input bit t, output bit pv);
        int dx, dy;
        pv = 1'b0;
        if (m_mode == 0) begin
            if (t) begin
                m_fill(x, y);
                m_tc = 1;
                pv = 1'b1;
                m_mode = (TOUCH_CNT == 1) ? 2 : 1;
            end
        end else if (m_mode == 1) begin
            if (t) begin
                m_put(x, y);
                m_tc++;
                pv = 1'b1;
                if (m_tc == TOUCH_CNT) m_mode = 2;
            end else begin
                m_mode = 0;
                m_tc = 0;
            end
        end else begin
            if (t) begin
                m_lc = 0;
                dx = x - m_mean(1'b0); if (dx < 0) dx = -dx;
                dy = y - m_mean(1'b1); if (dy < 0) dy = -dy;
                if (dx <= JUMP_MAX && dy <= JUMP_MAX) begin
                    m_put(x, y); m_rc = 0; pv = 1'b1;
                end else if (m_rc < REJECT_MAX) begin
                    m_rc++;
                    if (m_rej < 255) m_rej++;
                end else begin
                    m_fill(x, y); m_rc = 0; pv = 1'b1;
                end
            end else begin
                m_lc++;
                if (m_lc == LOST_CNT) begin
                    m_mode = 0; m_lc = 0; m_rc = 0;
                end
            end
        end
    endtask

    // Issue one frame: level low, rising edge with junk data, valid data one cycle later.
    task automatic apply_frame(input int x, input int y, input bit t, input int gap);
        exp_t e;
        bit   pv;
        frame_valid_in = 1'b0;
        step();
        step();
        frame_valid_in = 1'b1;
        x_in = 12'($urandom); y_in = 12'($urandom); touched_in = 8'($urandom);
        e.cyc = cyc + 3;
        step();
        x_in = 12'(x); y_in = 12'(y);
        touched_in = t ? 8'($urandom_range(1, 255)) : 8'd0;
        step();
        x_in = 12'($urandom); y_in = 12'($urandom); touched_in = 8'($urandom);
        model_frame(x, y, t, pv);
        e.pv = pv;
        e.px = m_mean(1'b0);
        e.py = m_mean(1'b1);
        e.bp = (m_mode == 2);
        e.rc = m_rej;
        sbq.push_back(e);
        repeat (gap) step();
    endtask

    // Monitor: each scheduled frame result is checked in its cycle; any other strobe is an error.
    always @(negedge clk) begin
        if (!rst) begin
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                mon_e = sbq.pop_front();
                chk("pos_valid", int'(pos_valid), int'(mon_e.pv));
                chk("pos_x", int'(pos_x), mon_e.px);
                chk("pos_y", int'(pos_y), mon_e.py);
                chk("ball_present", int'(ball_present), int'(mon_e.bp));
                chk("reject_cnt", int'(reject_cnt), mon_e.rc);
            end else if (pos_valid) begin
                chk("unexpected_pos_valid", int'(pos_valid), 0);
            end
        end
    end

    initial begin
        int x, y;
        bit t;
        model_reset();
        rst = 1'b1;
        frame_valid_in = 1'b1;
        repeat (5) step();
        rst = 1'b0;
        repeat (100) step();
        chk("rst_pos_valid", int'(pos_valid), 0);
        chk("rst_ball_present", int'(ball_present), 0);
        chk("rst_pos_x", int'(pos_x), 0);
        chk("rst_pos_y", int'(pos_y), 0);
        chk("rst_reject_cnt", int'(reject_cnt), 0);
        chk("rst_stale", int'(stale), 0);

        // First frames after reset: preload then acquire.
        apply_frame(1000, 2000, 1'b1, 2);
        chk("first_pos_x", int'(pos_x), 1000);
        chk("first_bp", int'(ball_present), 0);
        apply_frame(1000, 2000, 1'b1, 2);
        chk("second_bp", int'(ball_present), 1);

        // Averaging with wrap and truncation.
        repeat (3) apply_frame(0, 0, 1'b0, 1);
        repeat (2) apply_frame(1000, 1000, 1'b1, 1);
        apply_frame(1040, 1000, 1'b1, 1);
        apply_frame(1080, 1000, 1'b1, 1);
        apply_frame(1120, 1000, 1'b1, 1);
        apply_frame(1160, 1000, 1'b1, 2);
        chk("avg_pos_x", int'(pos_x), 1100);

        // Outlier rejection then forced accept.
        repeat (3) apply_frame(0, 0, 1'b0, 1);
        repeat (2) apply_frame(1000, 1000, 1'b1, 1);
        repeat (3) apply_frame(1500, 1000, 1'b1, 2);
        chk("outlier_reject_cnt", int'(reject_cnt), 3);
        apply_frame(1500, 1000, 1'b1, 2);
        chk("outlier_pos_x", int'(pos_x), 1500);

        // Loss debounce.
        repeat (2) apply_frame(0, 0, 1'b0, 2);
        chk("loss_bp_held", int'(ball_present), 1);
        apply_frame(1500, 1000, 1'b1, 1);
        repeat (3) apply_frame(0, 0, 1'b0, 2);
        chk("loss_bp_cleared", int'(ball_present), 0);
        chk("loss_pos_hold", int'(pos_x), 1500);

        // Reset in the middle of a frame.
        frame_valid_in = 1'b0;
        step();
        step();
        frame_valid_in = 1'b1;
        step();
        x_in = 12'd3000; y_in = 12'd3000; touched_in = 8'd1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_reset();
        repeat (10) step();
        chk("midrst_pos_x", int'(pos_x), 0);
        chk("midrst_bp", int'(ball_present), 0);
        chk("midrst_reject_cnt", int'(reject_cnt), 0);
        apply_frame(500, 600, 1'b1, 2);
        chk("after_rst_pos_x", int'(pos_x), 500);

`ifdef TOUCH_TIMEOUT_EN
        // Watchdog expiry and recovery.
        apply_frame(500, 600, 1'b1, 2);
        repeat (TMO + 10) step();
        chk("tmo_stale", int'(stale), 1);
        chk("tmo_bp", int'(ball_present), 0);
        m_mode = 0; m_tc = 0; m_lc = 0; m_rc = 0;
        apply_frame(700, 700, 1'b1, 2);
        chk("tmo_stale_clear", int'(stale), 0);
`endif

        // Random frames around the current mean with occasional far jumps.
        for (int k = 0; k < 300; k++) begin
            t = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) == 0) begin
                x = $urandom_range(0, 4095);
                y = $urandom_range(0, 4095);
            end else begin
                x = m_mean(1'b0) + int'($urandom_range(0, 500)) - 250;
                y = m_mean(1'b1) + int'($urandom_range(0, 500)) - 250;
            end
            if (x < 0) x = 0;
            if (x > 4095) x = 4095;
            if (y < 0) y = 0;
            if (y > 4095) y = 4095;
            apply_frame(x, y, t, $urandom_range(0, 3));
        end

        repeat (10) step();
        chk("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/touch_pos_filter.md
Name: touch_pos_filter

Overview:
- Consumes the decoded touch-panel frame (x, y, touched, frame-valid level) produced by the SPI slave stage.
- Detects each new frame and debounces the touch/no-touch state.
- Rejects single-frame coordinate jumps and outputs a moving-average ball position with a one-cycle strobe to the downstream plate controller.

Parameters:
- AVG_LOG2, 2, log2 of the moving-average depth (depth N = 2^AVG_LOG2; legal range 1..4).
- TOUCH_CNT, 2, consecutive touched frames needed to assert ball_present (legal range ≥1).
- LOST_CNT, 3, consecutive untouched frames needed to deassert ball_present (legal range ≥1).
- JUMP_MAX, 200, maximum per-axis |sample − current mean| accepted in TRACK.
- REJECT_MAX, 3, consecutive rejected frames after which the next out-of-range sample is force-accepted.
- TIMEOUT_CYCLES, 5000000, frame watchdog period in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- x_in  in  12  raw X coordinate from the SPI slave
- y_in  in  12  raw Y coordinate from the SPI slave
- touched_in  in  8  touch flag byte; any nonzero value = touched
- frame_valid_in  in  1  level, high between frames; a rising edge marks frame completion
- pos_x  out  12  filtered X (mean of buffer)
- pos_y  out  12  filtered Y
- pos_valid  out  1  one-cycle strobe, pos_x/pos_y updated
- ball_present  out  1  debounced touch state
- reject_cnt  out  8  saturating count of rejected frames since reset
- stale  out  1  watchdog expired (tied 0 when the optional feature is off)

Behaviour:
- Reset values: pos_x=0, pos_y=0, pos_valid=0, ball_present=0, reject_cnt=0, stale=0, state=IDLE, buffers/sums/counters=0, valid_q=1.
- valid_q resets to 1, so a level already high after reset is not treated as a frame.
- Frame detect:
  - cycle t where frame_valid_in=1 and valid_q=0 (valid_q is frame_valid_in delayed 1 cycle).
  - x_in/y_in/touched_in are sampled at the end of cycle t+1, because the upstream coordinate registers update one cycle after the level rises.
  - pos_valid pulses in cycle t+3: fixed latency 3 from the edge cycle.
- A second rising edge while a frame is in flight (edges closer than 3 cycles) is dropped. This is legal only from a misbehaving upstream; frames are ≥32 SCLK apart.
- Mean per axis:
  - sum width = 12+AVG_LOG2.
  - Circular buffer of N entries; a single write pointer is shared by both axes and wraps N−1 to 0.
  - Accept: sum ← sum − buf[wp] + new; buf[wp] ← new; wp++.
  - Preload: all entries ← new; sum ← new<<AVG_LOG2; wp ← 0.
  - pos = sum>>AVG_LOG2 (truncate).
- State machine (advances only on sampled frames):
  - IDLE:
    - touched → preload both axes, tcnt=1.
    - If TOUCH_CNT=1 → TRACK and assert ball_present; else → ACQUIRE.
    - Untouched → stay; no pos_valid.
  - ACQUIRE:
    - touched → accept (no jump check), tcnt++; at tcnt=TOUCH_CNT → TRACK and assert ball_present.
    - Untouched → IDLE, tcnt=0.
    - pos_valid is issued for each accepted frame.
  - TRACK, touched frame:
    - In range (both |x−pos_x|≤JUMP_MAX and |y−pos_y|≤JUMP_MAX, differences as 13-bit signed): accept, rcnt=0, pos_valid.
    - Out of range with rcnt<REJECT_MAX: reject; buffer unchanged; rcnt++; reject_cnt++ (saturate at 255); no pos_valid.
    - Out of range with rcnt=REJECT_MAX: preload with the new sample, rcnt=0, pos_valid.
    - lcnt=0 on every touched frame.
  - TRACK, untouched frame:
    - lcnt++; no buffer change, no pos_valid.
    - At lcnt=LOST_CNT → IDLE; ball_present=0; lcnt=0, rcnt=0. pos_x/pos_y hold their last values.
- rst mid-frame aborts the frame; no pos_valid after rst release until a new rising edge.

Optional Feature:
- Macro: TOUCH_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on each frame-detect edge and otherwise counts.
  - At TIMEOUT_CYCLES without an edge: stale=1, ball_present=0, state → IDLE, all frame counters cleared.
  - stale clears on the next detected frame edge.
- Undefined: no counter is built; stale is tied 0.

Decomposition:
- Package touch_pkg:
  - state encoding: IDLE, ACQUIRE, TRACK.
  - COORD_W=12 and FLAG_W=8.
  - default AVG_LOG2, JUMP_MAX, TOUCH_CNT, LOST_CNT, REJECT_MAX.
- Sub-module touch_avg_axis: one per axis, instantiated twice.
  - Contains the buffer, running sum, and mean.
  - Controls: accept, preload, sample; output: mean.
  - Write pointer is supplied by the parent so both axes stay aligned.

Test Plan:
- Reset with frame_valid_in held high: no pos_valid or ball_present for 100 cycles; the first 0→1 edge with touched=1, x=1000, y=2000 → pos_valid exactly 3 cycles after the edge, pos=(1000,2000), ball_present=1 (after the 2nd touched frame with TOUCH_CNT=2).
- Averaging: in TRACK after preload at (1000,1000), feed x=1040,1080,1120,1160 with y fixed → pos_x=1010,1030,1060,1100. Checks N=4 wrap and truncation.
- Outlier: TRACK at pos_x=1000, frames x=1500 ×3 → no pos_valid, reject_cnt=3; 4th frame x=1500 → preload, pos_x=1500, pos_valid.
- Loss debounce: TRACK, then untouched ×2 → ball_present stays 1; one touched frame, then untouched ×3 → ball_present=0 after the 3rd, pos holds its last value.
- Mid-frame rst: assert rst one cycle after an edge → no pos_valid; all outputs at reset values; the next frame starts from IDLE.
- With TOUCH_TIMEOUT_EN and TIMEOUT_CYCLES=1000: TRACK, then no edges for 1000 cycles → stale=1, ball_present=0; the next edge → stale=0.
